// File: rtl/console_text_writer.sv
// Byte-stream terminal front-end: places printable characters at the cursor,
// handles CR/LF/BS/FF, and scrolls the text buffer up when output runs off the last row.
module console_text_writer #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  char_in,
    input  logic                        char_valid,
    output logic                        char_ready,
    output logic                        wr_en,
    output logic [5:0]                  wr_addr,
    output logic [6:0]                  wr_data,
    output logic [5:0]                  rd_addr,
    input  logic [6:0]                  rd_data,
    output logic [$clog2(NUM_ROWS)-1:0] cursor_row,
    output logic [$clog2(NUM_COLS)-1:0] cursor_col,
    output logic                        busy
);
    localparam int RW        = $clog2(NUM_ROWS);
    localparam int CW        = $clog2(NUM_COLS);
    localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;

    localparam logic [RW-1:0] LAST_ROW   = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL   = CW'(NUM_COLS - 1);
    localparam logic [5:0]    COLS6      = 6'(NUM_COLS);
    localparam logic [5:0]    COPY_LAST  = 6'(NUM_CHARS - NUM_COLS - 1);
    localparam logic [5:0]    FILL_START = 6'(NUM_CHARS - NUM_COLS);
    localparam logic [5:0]    LAST_IDX   = 6'(NUM_CHARS - 1);
    localparam logic [6:0]    SPACE      = 7'h20;

    typedef enum logic [1:0] {IDLE, WRITE, COPY, FILL} state_t;

    state_t        state, state_n;
    logic [RW-1:0] row, row_n;
    logic [CW-1:0] col, col_n;
    logic [5:0]    idx, idx_n;
    logic [5:0]    lat_addr, lat_addr_n;
    logic [6:0]    lat_data, lat_data_n;
    logic          bs_wr, bs_n;
    logic [5:0]    cur_addr;

    assign cur_addr = 6'(row) * COLS6 + 6'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            idx      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            bs_wr    <= 1'b0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            col      <= col_n;
            idx      <= idx_n;
            lat_addr <= lat_addr_n;
            lat_data <= lat_data_n;
            bs_wr    <= bs_n;
        end
    end

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        idx_n      = idx;
        lat_addr_n = lat_addr;
        lat_data_n = lat_data;
        bs_n       = bs_wr;
        case (state)
            IDLE: begin
                if (char_valid) begin
                    if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                        lat_addr_n = cur_addr;
                        lat_data_n = char_in[6:0];
                        bs_n       = 1'b0;
                        state_n    = WRITE;
                    end else begin
                        case (char_in)
                            8'h0A: begin
                                col_n = '0;
                                if (row < LAST_ROW) begin
                                    row_n = row + 1'b1;
                                end else begin
                                    idx_n   = '0;
                                    state_n = COPY;
                                end
                            end
                            8'h0D: col_n = '0;
                            8'h08: begin
                                // Backspace never wraps to the previous row.
                                if (col != '0) begin
                                    col_n      = col - 1'b1;
                                    lat_addr_n = cur_addr - 6'd1;
                                    lat_data_n = SPACE;
                                    bs_n       = 1'b1;
                                    state_n    = WRITE;
                                end
                            end
                            8'h0C: begin
                                row_n   = '0;
                                col_n   = '0;
                                idx_n   = '0;
                                state_n = FILL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                state_n = IDLE;
                if (!bs_wr) begin
                    if (col < LAST_COL) begin
                        col_n = col + 1'b1;
                    end else begin
                        col_n = '0;
                        if (row < LAST_ROW) begin
                            row_n = row + 1'b1;
                        end else begin
                            idx_n   = '0;
                            state_n = COPY;
                        end
                    end
                end
            end
            COPY: begin
                if (idx == COPY_LAST) begin
                    idx_n   = FILL_START;
                    state_n = FILL;
                end else begin
                    idx_n = idx + 6'd1;
                end
            end
            FILL: begin
                if (idx == LAST_IDX) state_n = IDLE;
                else                 idx_n   = idx + 6'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode only from registered state, so reset drops wr_en immediately.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        case (state)
            WRITE: begin
                wr_en   = 1'b1;
                wr_addr = lat_addr;
                wr_data = lat_data;
            end
            COPY: begin
                wr_en   = 1'b1;
                wr_addr = idx;
                rd_addr = idx + COLS6;
                wr_data = rd_data;
            end
            FILL: begin
                wr_en   = 1'b1;
                wr_addr = idx;
                wr_data = SPACE;
            end
            default: ;
        endcase
    end

    assign char_ready = (state == IDLE);
    assign busy       = !char_ready;
    assign cursor_row = row;
    assign cursor_col = col;
endmodule

// File: tb/tb_console_text_writer.sv
// Directed bench for console_text_writer with a behavioural text-buffer model.
module tb_console_text_writer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready, wr_en, busy;
    logic [5:0] wr_addr, rd_addr;
    logic [6:0] wr_data, rd_data;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;

    logic [6:0] mem [0:63];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_wr = 0;
    int         snap;

    console_text_writer dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .cursor_row(cursor_row),
        .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        char_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Presents a byte for one cycle; returns on the following negedge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        char_in = b;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic chk_cursor(input string tag, input int r, input int c);
        chk({tag, "_row"}, 32'(cursor_row), 32'(r));
        chk({tag, "_col"}, 32'(cursor_col), 32'(c));
    endtask

    initial begin
        // 1: reset state and single printable
        do_reset();
        chk("rst_ready", 32'(char_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk_cursor("rst", 0, 0);
        send(8'h41);
        chk("t1_wr_en", 32'(wr_en), 1);
        chk("t1_addr", 32'(wr_addr), 0);
        chk("t1_data", 32'(wr_data), 32'h41);
        chk("t1_ready", 32'(char_ready), 0);
        chk("t1_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t1_ready_back", 32'(char_ready), 1);
        chk_cursor("t1", 0, 1);

        // 2: row of digits, then CR/LF without writes
        send(8'h0D);
        chk_cursor("t2_cr", 0, 0);
        for (int i = 0; i < 10; i++) begin
            send(8'h30 + 8'(i));
            chk("t2_wr_en", 32'(wr_en), 1);
            chk("t2_addr", 32'(wr_addr), 32'(i));
            chk("t2_data", 32'(wr_data), 32'h30 + 32'(i));
        end
        @(negedge clk);
        chk_cursor("t2_wrap", 1, 0);
        snap = n_wr;
        send(8'h0D);
        send(8'h0A);
        chk_cursor("t2_crlf", 2, 0);
        chk("t2_no_wr", 32'(n_wr - snap), 0);

        // 3: fill every cell, observe the scroll
        do_reset();
        for (int i = 0; i < 30; i++) send(8'h41 + 8'(i));
        chk("t3_last_addr", 32'(wr_addr), 29);
        for (int k = 0; k < 32; k++) begin
            if (k == 0) begin
                chk("t3_busy", 32'(busy), 1);
            end else if (k <= 20) begin
                chk("t3_cp_wr_en", 32'(wr_en), 1);
                chk("t3_cp_rd", 32'(rd_addr), 32'(k + 9));
                chk("t3_cp_wr", 32'(wr_addr), 32'(k - 1));
                chk("t3_cp_data", 32'(wr_data), 32'h41 + 32'(k + 9));
                chk_cursor("t3_mid", 2, 0);
            end else if (k <= 30) begin
                chk("t3_fl_wr_en", 32'(wr_en), 1);
                chk("t3_fl_addr", 32'(wr_addr), 32'(k - 1));
                chk("t3_fl_data", 32'(wr_data), 32'h20);
            end else begin
                chk("t3_idle_busy", 32'(busy), 0);
                chk("t3_idle_wr_en", 32'(wr_en), 0);
            end
            @(negedge clk);
        end
        chk_cursor("t3_end", 2, 0);
        for (int a = 0; a < 30; a++)
            chk("t3_mem", 32'(mem[a]), (a < 20) ? 32'h41 + 32'(a + 10) : 32'h20);

        // 4: backspace, including at column 0
        do_reset();
        send(8'h41); send(8'h42); send(8'h43);
        @(negedge clk);
        chk_cursor("t4_pre", 0, 3);
        send(8'h08);
        chk("t4_bs_wr_en", 32'(wr_en), 1);
        chk("t4_bs_addr", 32'(wr_addr), 2);
        chk("t4_bs_data", 32'(wr_data), 32'h20);
        @(negedge clk);
        chk_cursor("t4_bs", 0, 2);
        send(8'h0A);
        chk_cursor("t4_lf", 1, 0);
        snap = n_wr;
        send(8'h08);
        chk("t4_bs0_wr_en", 32'(wr_en), 0);
        chk("t4_bs0_ready", 32'(char_ready), 1);
        chk("t4_bs0_no_wr", 32'(n_wr - snap), 0);
        chk_cursor("t4_bs0", 1, 0);

        // 5: clear screen, then discarded bytes
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        @(negedge clk);
        chk_cursor("t5_pre", 2, 5);
        send(8'h0C);
        for (int k = 0; k < 30; k++) begin
            chk("t5_ff_wr_en", 32'(wr_en), 1);
            chk("t5_ff_addr", 32'(wr_addr), 32'(k));
            chk("t5_ff_data", 32'(wr_data), 32'h20);
            @(negedge clk);
        end
        chk("t5_ready", 32'(char_ready), 1);
        chk_cursor("t5_ff", 0, 0);
        snap = n_wr;
        send(8'h07);
        chk("t5_bel_ready", 32'(char_ready), 1);
        send(8'h90);
        send(8'h7F);
        chk("t5_disc_no_wr", 32'(n_wr - snap), 0);
        chk_cursor("t5_disc", 0, 0);

        // 6: reset in the middle of a scroll
        do_reset();
        for (int i = 0; i < 30; i++) send(8'h30 + 8'(i));
        repeat (8) @(negedge clk);
        chk("t6_copy_idx", 32'(wr_addr), 7);
        chk("t6_copy_rd", 32'(rd_addr), 17);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_wr_en", 32'(wr_en), 0);
        chk("t6_async_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready", 32'(char_ready), 1);
        chk_cursor("t6", 0, 0);
        send(8'h5A);
        chk("t6_addr", 32'(wr_addr), 0);
        chk("t6_data", 32'(wr_data), 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
